// File: rtl/audio_capture_controller.sv
// Stereo audio capture: samples L/R on each sample-strobe level change into a
// small FIFO that the CPU drains through the 4-bit request/ready register port.
module audio_capture_controller #(
  parameter int          BUFFER_SIZE  = 16,
  parameter logic [31:0] DEFAULT_RATE = 32'd17
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [3:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  input  logic        i_input_sample_clock,
  input  logic [15:0] i_input_sample_left,
  input  logic [15:0] i_input_sample_right,
  output logic [31:0] o_input_sample_rate
);

  localparam int AW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int CW = $clog2(BUFFER_SIZE) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_SIZE);

  logic [31:0]   mem [BUFFER_SIZE];

  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   rate_q, rate_d;
  logic          enable_q, enable_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic [15:0]   drop_q, drop_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_clk_q, last_clk_d;

  logic          access, is_rd, is_wr;
  logic          fifo_full, fifo_empty;
  logic          capture, flush, pop, push, drop;
  logic [31:0]   rd_val;
  logic [31:0]   status;

  always_comb begin
    access     = i_request & ~ready_q;
    is_rd      = access & ~i_rw;
    is_wr      = access & i_rw;
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    capture    = enable_q & (i_input_sample_clock != last_clk_q);
    flush      = is_wr & (i_address == 4'h3) & i_wdata[3];
    pop        = is_rd & (i_address == 4'h0) & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push       = capture & ~flush & (~fifo_full | pop);
    drop       = capture & ~flush & fifo_full & ~pop;
    status     = {drop_q, 11'd0, fifo_empty, fifo_full,
                  underflow_q, overflow_q, enable_q};

    rd_val = '0;
    if (is_rd) begin
      case (i_address)
        4'h0:    rd_val = fifo_empty ? 32'd0 : mem[rd_ptr_q];
        4'h1:    rd_val = {{(32-CW){1'b0}}, count_q};
        4'h2:    rd_val = rate_q;
        4'h3:    rd_val = status;
        default: rd_val = '0;
      endcase
    end

    ready_d     = i_request;
    rdata_d     = access ? rd_val : (i_request ? rdata_q : 32'd0);
    rate_d      = rate_q;
    enable_d    = enable_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    drop_d      = drop_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    last_clk_d  = i_input_sample_clock;

    if (is_wr && i_address == 4'h2) rate_d = i_wdata;
    if (is_wr && i_address == 4'h3) begin
      enable_d = i_wdata[0];
      if (i_wdata[1]) overflow_d  = 1'b0;
      if (i_wdata[2]) underflow_d = 1'b0;
    end
    if (is_rd && i_address == 4'h0 && fifo_empty) underflow_d = 1'b1;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      drop_d   = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      rate_q      <= DEFAULT_RATE;
      enable_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_clk_q  <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      rate_q      <= rate_d;
      enable_q    <= enable_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      drop_q      <= drop_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_clk_q  <= last_clk_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr_q] <= {i_input_sample_left, i_input_sample_right};
  end

  assign o_ready             = ready_q;
  assign o_rdata             = rdata_q;
  assign o_input_sample_rate = rate_q;

endmodule

// File: tb/tb_audio_capture_controller.sv
// Scenario bench for audio_capture_controller with a sample scoreboard and a
// small behavioural model of the status/control registers.
module tb_audio_capture_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_request, i_rw;
  logic [3:0]  i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        strobe;
  logic [15:0] s_left, s_right;
  logic [31:0] o_rate;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];
  bit          m_en, m_ovf, m_udf;
  int          m_drop;
  logic [15:0] seq;

  audio_capture_controller #(.BUFFER_SIZE(16), .DEFAULT_RATE(32'd17)) dut (
    .i_clock(clk), .i_reset(rst), .i_request(i_request), .i_rw(i_rw),
    .i_address(i_address), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_ready(o_ready), .i_input_sample_clock(strobe),
    .i_input_sample_left(s_left), .i_input_sample_right(s_right),
    .o_input_sample_rate(o_rate)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] status_exp();
    logic [15:0] d;
    d = 16'(m_drop);
    return {d, 11'd0, sb_q.size() == 0, sb_q.size() == 16, m_udf, m_ovf, m_en};
  endfunction

  task automatic model_reset();
    sb_q.delete();
    m_en = 0; m_ovf = 0; m_udf = 0; m_drop = 0;
  endtask

  task automatic model_capture(input logic [31:0] s);
    if (m_en) begin
      if (sb_q.size() < 16) sb_q.push_back(s);
      else begin
        m_ovf = 1;
        if (m_drop < 16'hFFFF) m_drop++;
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      errors++;
      $display("FAIL ready_timeout addr=%0h", i_address);
    end
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    bit ok;
    @(negedge clk);
    i_request = 1; i_rw = 0; i_address = a;
    wait_ready(ok);
    d = o_rdata;
    i_request = 0;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] w);
    bit ok;
    @(negedge clk);
    i_request = 1; i_rw = 1; i_address = a; i_wdata = w;
    wait_ready(ok);
    i_request = 0;
    @(negedge clk);
    if (a == 4'h2) begin
      checks++;
      if (o_rate !== w) begin
        errors++; $display("FAIL rate_out got=%0d exp=%0d", o_rate, w);
      end
    end
    if (a == 4'h3) begin
      m_en = w[0];
      if (w[1]) m_ovf = 0;
      if (w[2]) m_udf = 0;
      if (w[3]) begin sb_q.delete(); m_drop = 0; end
    end
  endtask

  task automatic toggle(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    s_left = l; s_right = r; strobe = ~strobe;
    model_capture({l, r});
    @(negedge clk);
  endtask

  task automatic pop_check(input string name);
    logic [31:0] d, e;
    if (sb_q.size() == 0) begin e = 0; m_udf = 1; end
    else e = sb_q.pop_front();
    do_read(4'h0, d);
    checks++;
    if (d !== e) begin errors++; $display("FAIL %s got=%08h exp=%08h", name, d, e); end
  endtask

  task automatic count_check(input string name);
    logic [31:0] d;
    do_read(4'h1, d);
    checks++;
    if (d !== 32'(sb_q.size())) begin
      errors++; $display("FAIL %s got=%0d exp=%0d", name, d, sb_q.size());
    end
  endtask

  task automatic status_check(input string name);
    logic [31:0] d, e;
    e = status_exp();
    do_read(4'h3, d);
    checks++;
    if (d !== e) begin errors++; $display("FAIL %s got=%08h exp=%08h", name, d, e); end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_ready !== 1'b0 || o_rdata !== 32'd0 || o_rate !== 32'd17) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rdata=%08h rate=%0d exp 0/0/17", o_ready, o_rdata, o_rate);
    end
    rst = 0;
    model_reset();
    do_read(4'h2, d);
    checks++;
    if (d !== 32'd17) begin errors++; $display("FAIL reset_rate got=%0d exp=17", d); end
    status_check("reset_status");
    pop_check("reset_empty_pop");
    status_check("reset_underflow_status");
  endtask

  task automatic test_capture_order();
    do_write(4'h3, 32'h1);
    toggle(16'h1111, 16'h2222);
    toggle(16'h3333, 16'h4444);
    toggle(16'h5555, 16'h6666);
    count_check("order_count3");
    for (int i = 0; i < 3; i++) pop_check("order_pop");
    count_check("order_count0");
  endtask

  task automatic test_overflow();
    do_write(4'h3, 32'h7);
    for (int i = 0; i < 20; i++) begin
      toggle(seq, ~seq);
      seq++;
    end
    status_check("ovf_status");
    checks++;
    if (m_drop != 4) begin errors++; $display("FAIL ovf_model_drop got=%0d exp=4", m_drop); end
    do_write(4'h3, 32'h3);
    status_check("ovf_cleared_status");
  endtask

  task automatic test_pop_full_capture();
    logic [31:0] d, e;
    bit ok;
    @(negedge clk);
    i_request = 1; i_rw = 0; i_address = 4'h0;
    s_left = 16'hBEEF; s_right = 16'hCAFE; strobe = ~strobe;
    e = sb_q.pop_front();
    sb_q.push_back({16'hBEEF, 16'hCAFE});
    wait_ready(ok);
    d = o_rdata;
    i_request = 0;
    @(negedge clk);
    checks++;
    if (d !== e) begin errors++; $display("FAIL popfull_data got=%08h exp=%08h", d, e); end
    count_check("popfull_count16");
    status_check("popfull_status");
    for (int i = 0; i < 16; i++) pop_check("popfull_drain");
    count_check("popfull_count0");
  endtask

  task automatic test_flush_disable();
    logic [31:0] d;
    toggle(16'hA000, 16'h0001);
    toggle(16'hA001, 16'h0002);
    do_write(4'h3, 32'h9);
    count_check("flush_count");
    status_check("flush_status");
    do_write(4'h3, 32'h0);
    for (int i = 0; i < 5; i++) toggle(16'h7000 + 16'(i), 16'h0);
    count_check("disabled_count");
    do_write(4'h2, 32'd34);
    do_read(4'h2, d);
    checks++;
    if (d !== 32'd34) begin errors++; $display("FAIL rate_readback got=%0d exp=34", d); end
  endtask

  task automatic test_handshake_reset();
    int highs;
    logic [31:0] d, e;
    bit ok;
    do_write(4'h3, 32'h1);
    toggle(16'h0C01, 16'h0D01);
    toggle(16'h0C02, 16'h0D02);
    @(negedge clk);
    i_request = 1; i_rw = 0; i_address = 4'h0;
    e = sb_q.pop_front();
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      if (o_ready) highs++;
      @(negedge clk);
    end
    d = o_rdata;
    i_request = 0;
    @(negedge clk);
    checks++;
    if (highs != 9) begin errors++; $display("FAIL hold_ready_cycles got=%0d exp=9", highs); end
    checks++;
    if (d !== e) begin errors++; $display("FAIL hold_data got=%08h exp=%08h", d, e); end
    count_check("hold_single_pop");

    toggle(16'h0C03, 16'h0D03);
    @(negedge clk);
    i_request = 1; i_rw = 0; i_address = 4'h1;
    wait_ready(ok);
    #2 rst = 1;
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_rdata !== 32'd0) begin
      errors++; $display("FAIL async_reset ready=%b rdata=%08h exp 0/0", o_ready, o_rdata);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    wait_ready(ok);
    d = o_rdata;
    i_request = 0;
    @(negedge clk);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL post_reset_count got=%0d exp=0", d); end
    status_check("post_reset_status");
  endtask

  initial begin
    rst = 1; i_request = 0; i_rw = 0; i_address = 0; i_wdata = 0;
    strobe = 0; s_left = 0; s_right = 0; seq = 16'h0100;
    model_reset();
    test_reset();
    test_capture_order();
    test_overflow();
    test_pop_full_capture();
    test_flush_disable();
    test_handshake_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
